// File: rtl/isp_dgain_bayer.sv
// Per-Bayer-channel digital gain with signed black-level offset.
// Gains, offset, pattern and enable are latched on each vsync rise.
module isp_dgain_bayer #(
  parameter int BITS      = 8,
  parameter int GAIN_BITS = 8,
  parameter int GAIN_FRAC = 4,
  parameter int WIDTH     = 1280,
  parameter int HEIGHT    = 960
) (
  input  logic                 pclk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [1:0]           bayer,
  input  logic [GAIN_BITS-1:0] gain_r,
  input  logic [GAIN_BITS-1:0] gain_gr,
  input  logic [GAIN_BITS-1:0] gain_gb,
  input  logic [GAIN_BITS-1:0] gain_b,
  input  logic [BITS:0]        offset,
  input  logic                 in_href,
  input  logic                 in_vsync,
  input  logic [BITS-1:0]      in_raw,
  output logic                 out_href,
  output logic                 out_vsync,
  output logic [BITS-1:0]      out_raw
);

  localparam int PW = BITS + GAIN_BITS;
  localparam int SW = PW + 2;
  localparam logic [GAIN_BITS-1:0] UNITY = GAIN_BITS'(1) << GAIN_FRAC;
  localparam logic signed [SW-1:0] RND  = SW'(1) << (GAIN_FRAC - 1);
  localparam logic signed [SW-1:0] MAXV = SW'((1 << BITS) - 1);

  if (GAIN_FRAC < 1 || GAIN_FRAC >= GAIN_BITS ||
      WIDTH < 1 || HEIGHT < 1) begin : g_param_chk
    $error("isp_dgain_bayer: illegal parameters");
  end

  logic                   vs_prev;
  logic                   href_prev;
  logic                   vs_rise;
  logic                   href_fall;
  logic                   en_sh;
  logic [1:0]             bayer_sh;
  logic [GAIN_BITS-1:0]   gr_sh;
  logic [GAIN_BITS-1:0]   ggr_sh;
  logic [GAIN_BITS-1:0]   ggb_sh;
  logic [GAIN_BITS-1:0]   gb_sh;
  logic signed [BITS:0]   off_sh;
  logic                   col_par;
  logic                   row_par;
  logic [1:0]             idx;
  logic [GAIN_BITS-1:0]   gain_sel;

  logic [PW-1:0]          prod1;
  logic [BITS-1:0]        raw1;
  logic                   en1;
  logic signed [BITS:0]   off1;
  logic signed [SW-1:0]   off_ext;
  logic signed [SW-1:0]   sum2;
  logic [BITS-1:0]        raw2;
  logic                   en2;
  logic signed [SW-1:0]   q;
  logic [BITS-1:0]        res;
  logic [2:0]             h_d;
  logic [2:0]             v_d;

  assign vs_rise   = in_vsync & ~vs_prev;
  assign href_fall = href_prev & ~in_href;
  assign idx       = {row_par, col_par} ^ bayer_sh;

  always_comb begin
    gain_sel = gr_sh;
    unique case (idx)
      2'd0: gain_sel = gr_sh;
      2'd1: gain_sel = ggr_sh;
      2'd2: gain_sel = ggb_sh;
      2'd3: gain_sel = gb_sh;
    endcase
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      vs_prev   <= 1'b0;
      href_prev <= 1'b0;
      en_sh     <= 1'b1;
      bayer_sh  <= 2'd0;
      gr_sh     <= UNITY;
      ggr_sh    <= UNITY;
      ggb_sh    <= UNITY;
      gb_sh     <= UNITY;
      off_sh    <= '0;
      col_par   <= 1'b0;
      row_par   <= 1'b0;
    end else begin
      vs_prev   <= in_vsync;
      href_prev <= in_href;
      if (vs_rise) begin
        en_sh    <= enable;
        bayer_sh <= bayer;
        gr_sh    <= gain_r;
        ggr_sh   <= gain_gr;
        ggb_sh   <= gain_gb;
        gb_sh    <= gain_b;
        off_sh   <= $signed(offset);
      end
      if (href_fall)
        col_par <= 1'b0;
      else if (in_href)
        col_par <= ~col_par;
      if (vs_rise)
        row_par <= 1'b0;
      else if (href_fall)
        row_par <= ~row_par;
    end
  end

  // enable and offset travel with the pixel so a frame edge never mixes controls
  assign off_ext = {{(SW-BITS-1){off1[BITS]}}, off1};
  assign q       = sum2 >>> GAIN_FRAC;

  always_comb begin
    res = q[BITS-1:0];
    if (q < 0)
      res = '0;
    else if (q > MAXV)
      res = '1;
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      prod1   <= '0;
      raw1    <= '0;
      en1     <= 1'b0;
      off1    <= '0;
      sum2    <= '0;
      raw2    <= '0;
      en2     <= 1'b0;
      h_d     <= '0;
      v_d     <= '0;
      out_raw <= '0;
    end else begin
      prod1   <= in_raw * gain_sel;
      raw1    <= in_raw;
      en1     <= en_sh;
      off1    <= off_sh;
      sum2    <= $signed({2'b00, prod1}) + (off_ext <<< GAIN_FRAC) + RND;
      raw2    <= raw1;
      en2     <= en1;
      h_d     <= {h_d[1:0], in_href};
      v_d     <= {v_d[1:0], in_vsync};
      out_raw <= h_d[1] ? (en2 ? res : raw2) : '0;
    end
  end

  assign out_href  = h_d[2];
  assign out_vsync = v_d[2];

endmodule

// File: tb/tb_isp_dgain_bayer.sv
// Self-checking bench for isp_dgain_bayer.
// Reference model tracks row/column counts and applies the gain formula.
module tb_isp_dgain_bayer;

  localparam int FR = 4;

  logic       pclk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [1:0] bayer;
  logic [7:0] gain_r, gain_gr, gain_gb, gain_b;
  logic [8:0] offset;
  logic       in_href, in_vsync;
  logic [7:0] in_raw;
  logic       out_href, out_vsync;
  logic [7:0] out_raw;

  isp_dgain_bayer #(
    .BITS(8), .GAIN_BITS(8), .GAIN_FRAC(FR), .WIDTH(16), .HEIGHT(8)
  ) dut (
    .pclk(pclk), .rst_n(rst_n), .enable(enable), .bayer(bayer),
    .gain_r(gain_r), .gain_gr(gain_gr), .gain_gb(gain_gb), .gain_b(gain_b),
    .offset(offset), .in_href(in_href), .in_vsync(in_vsync),
    .in_raw(in_raw), .out_href(out_href), .out_vsync(out_vsync),
    .out_raw(out_raw)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic       h;
    logic       v;
    logic [7:0] r;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  int m_g[4];
  int m_off;
  bit m_en;
  int m_bay;
  int row, col;
  bit m_vp, m_hp;

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] expv);
    checks++;
    assert (got === expv) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d t=%0t", tag, got, expv, $time);
    end
  endtask

  function automatic int model_px(input int p);
    int idx, t, o;
    if (!m_en) return p;
    idx = (((row % 2) * 2) + (col % 2)) ^ m_bay;
    t = p * m_g[idx] + m_off * (1 << FR) + (1 << (FR - 1));
    o = t >>> FR;
    if (o < 0) o = 0;
    if (o > 255) o = 255;
    return o;
  endfunction

  task automatic model_reset();
    exp_t z;
    for (int i = 0; i < 4; i++) m_g[i] = 1 << FR;
    m_off = 0;
    m_en  = 1'b1;
    m_bay = 0;
    row = 0;
    col = 0;
    m_vp = 1'b0;
    m_hp = 1'b0;
    exp_q.delete();
    z.h = 1'b0; z.v = 1'b0; z.r = 8'd0;
    exp_q.push_back(z);
    exp_q.push_back(z);
  endtask

  task automatic cyc(input logic hr, input logic vs, input logic [7:0] px);
    exp_t e;
    bit vr, fall;
    in_href = hr;
    in_vsync = vs;
    in_raw = px;
    e.h = hr;
    e.v = vs;
    e.r = hr ? 8'(model_px(int'(px))) : 8'd0;
    exp_q.push_back(e);
    vr = vs && !m_vp;
    fall = m_hp && !hr;
    if (vr) begin
      m_en  = enable;
      m_bay = int'(bayer);
      m_g[0] = int'(gain_r);
      m_g[1] = int'(gain_gr);
      m_g[2] = int'(gain_gb);
      m_g[3] = int'(gain_b);
      m_off = int'($signed(offset));
    end
    if (hr) col++;
    else if (fall) col = 0;
    if (vr) row = 0;
    else if (fall) row++;
    m_vp = vs;
    m_hp = hr;
    @(posedge pclk);
    #1;
    if (exp_q.size() >= 3) begin
      e = exp_q.pop_front();
      chk("href", 16'(out_href), 16'(e.h));
      chk("vsync", 16'(out_vsync), 16'(e.v));
      chk("raw", 16'(out_raw), 16'(e.r));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'd0);
  endtask

  task automatic start_frame();
    cyc(1'b0, 1'b1, 8'd0);
    cyc(1'b0, 1'b1, 8'd0);
    idle(2);
  endtask

  task automatic line(input int n, input logic [7:0] base, input bit rnd);
    for (int i = 0; i < n; i++)
      cyc(1'b1, 1'b0, rnd ? 8'($urandom) : base);
    idle(3);
  endtask

  task automatic set_gains(input logic [7:0] r, gr, gb, b);
    gain_r = r; gain_gr = gr; gain_gb = gb; gain_b = b;
  endtask

  task automatic rand_cfg();
    set_gains(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    offset = 9'($urandom);
    bayer  = 2'($urandom);
    enable = ($urandom_range(0, 5) != 0);
  endtask

  initial begin
    rst_n = 1'b0;
    enable = 1'b1;
    bayer = 2'd0;
    set_gains(8'h10, 8'h10, 8'h10, 8'h10);
    offset = 9'd0;
    in_href = 1'b0;
    in_vsync = 1'b0;
    in_raw = 8'd0;
    #2;
    chk("rst_href", 16'(out_href), 16'd0);
    chk("rst_vsync", 16'(out_vsync), 16'd0);
    chk("rst_raw", 16'(out_raw), 16'd0);
    @(posedge pclk);
    @(posedge pclk);
    #1;
    rst_n = 1'b1;
    model_reset();
    idle(3);

    set_gains(8'h20, 8'h10, 8'h10, 8'h10);
    start_frame();
    line(8, 8'd100, 1'b0);
    line(8, 8'd100, 1'b0);

    start_frame();
    line(4, 8'd200, 1'b0);
    set_gains(8'h10, 8'h10, 8'h10, 8'h10);
    offset = 9'(-20);
    start_frame();
    line(4, 8'd10, 1'b0);
    offset = 9'd255;
    start_frame();
    line(4, 8'd255, 1'b0);
    set_gains(8'hFF, 8'h00, 8'hFF, 8'h00);
    offset = 9'd50;
    start_frame();
    line(4, 8'd255, 1'b0);
    offset = 9'd0;
    line(4, 8'd255, 1'b0);

    set_gains(8'h18, 8'h18, 8'h18, 8'h18);
    start_frame();
    line(4, 8'd3, 1'b0);
    line(4, 8'd1, 1'b0);
    set_gains(8'h14, 8'h14, 8'h14, 8'h14);
    start_frame();
    line(4, 8'd2, 1'b0);

    set_gains(8'h10, 8'h10, 8'h10, 8'h10);
    start_frame();
    line(6, 8'd40, 1'b0);
    gain_r = 8'h30;
    line(6, 8'd40, 1'b0);
    line(6, 8'd40, 1'b0);
    start_frame();
    line(6, 8'd40, 1'b0);

    set_gains(8'h08, 8'h10, 8'h20, 8'h30);
    for (int b = 1; b < 4; b++) begin
      bayer = 2'(b);
      start_frame();
      line(4, 8'd60, 1'b0);
      line(4, 8'd60, 1'b0);
    end

    enable = 1'b0;
    start_frame();
    line(8, 8'd0, 1'b1);
    line(8, 8'd0, 1'b1);
    enable = 1'b1;

    bayer = 2'd0;
    set_gains(8'h20, 8'h20, 8'h20, 8'h20);
    offset = 9'd5;
    start_frame();
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 8'd70);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_href", 16'(out_href), 16'd0);
    chk("mid_rst_vsync", 16'(out_vsync), 16'd0);
    chk("mid_rst_raw", 16'(out_raw), 16'd0);
    @(posedge pclk);
    @(posedge pclk);
    in_href = 1'b0;
    in_vsync = 1'b0;
    #1;
    rst_n = 1'b1;
    model_reset();
    line(6, 8'd0, 1'b1);
    line(6, 8'd0, 1'b1);
    start_frame();
    line(6, 8'd70, 1'b0);

    for (int f = 0; f < 8; f++) begin
      rand_cfg();
      start_frame();
      for (int l = 0; l < 4; l++) begin
        line($urandom_range(3, 10), 8'd0, 1'b1);
        if (l == 1) rand_cfg();
      end
    end
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
